dpwm_capture: RTL and testbench

Measurement block for the receiving end of the DPWM gate-drive interface. Samples the complementary gate pair (c1 high-side, c2 low-side) in the hf_clock domain, synchronizes it, and recovers per-period switching period, c1 on-time, and both deadtimes as hf_clock cycle counts. Used for closed-loop self-check of the DPWM output and for monitoring externally generated gate signals. Also flags shoot-through, counter overflow and malformed switching sequences.

---
 rtl/dpwm_capture_if.sv | 27 ++
 rtl/dpwm_capture.sv | 157 +++++++++++++++
 tb/tb_dpwm_capture.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpwm_capture_if.sv
// Gate-pair inputs and measurement results of the DPWM capture block.
interface dpwm_capture_if #(
    parameter int unsigned RESOLUTION = 12
);
    logic                  c1;
    logic                  c2;
    logic [RESOLUTION-1:0] period;
    logic [RESOLUTION-1:0] duty_cycle;
    logic [RESOLUTION-1:0] deadtime1;
    logic [RESOLUTION-1:0] deadtime2;
    logic                  meas_valid;
    logic                  seq_error;
    logic                  overflow;
    logic                  shoot_through;

    modport master (
        output c1, c2,
        input  period, duty_cycle, deadtime1, deadtime2,
        input  meas_valid, seq_error, overflow, shoot_through
    );

    modport slave (
        input  c1, c2,
        output period, duty_cycle, deadtime1, deadtime2,
        output meas_valid, seq_error, overflow, shoot_through
    );
endinterface

// File: rtl/dpwm_capture.sv
// Recovers period, c1 on-time and both deadtimes of a complementary gate pair as
// hf_clock cycle counts between consecutive c1 rising edges.
module dpwm_capture #(
    parameter int unsigned RESOLUTION  = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           hf_clock,
    input logic           reset,
    dpwm_capture_if.slave gate
);
    localparam logic [RESOLUTION-1:0] CntOne     = {{(RESOLUTION-1){1'b0}}, 1'b1};
    localparam logic [RESOLUTION-1:0] CntMax     = {RESOLUTION{1'b1}};
    localparam logic [RESOLUTION-1:0] CntNearMax = CntMax - CntOne;
    localparam logic [0:0] StWaitEdge = 1'b0;
    localparam logic [0:0] StMeasure  = 1'b1;

    logic [SYNC_STAGES-1:0] c1_sync_q, c2_sync_q;
    logic                   s1_prev_q, s2_prev_q;
    logic [0:0]             state_q, state_d;
    logic [RESOLUTION-1:0]  cnt_q, cnt_d;
    logic [RESOLUTION-1:0]  t_c1f_q, t_c1f_d, t_c2r_q, t_c2r_d, t_c2f_q, t_c2f_d;
    logic                   seen_c1f_q, seen_c1f_d, seen_c2r_q, seen_c2r_d;
    logic                   seen_c2f_q, seen_c2f_d, dup_q, dup_d;
    logic                   st_period_q, st_period_d, shoot_q, shoot_d;
    logic [RESOLUTION-1:0]  period_q, period_d, duty_q, duty_d;
    logic [RESOLUTION-1:0]  dt1_q, dt1_d, dt2_q, dt2_d;
    logic                   meas_valid_q, meas_valid_d, seq_error_q, seq_error_d;
    logic                   overflow_q, overflow_d;

    logic s1, s2, rise1, fall1, rise2, fall2, both;
    logic dup_now, st_now, all_seen, ordered, seq_ok, ovf_hit, new_period;

    assign s1    = c1_sync_q[SYNC_STAGES-1];
    assign s2    = c2_sync_q[SYNC_STAGES-1];
    assign rise1 = s1 & ~s1_prev_q;
    assign fall1 = ~s1 & s1_prev_q;
    assign rise2 = s2 & ~s2_prev_q;
    assign fall2 = ~s2 & s2_prev_q;
    assign both  = s1 & s2;

    // Events landing in the c1-rise cycle still belong to the period being closed.
    assign t_c1f_d  = fall1 ? cnt_q : t_c1f_q;
    assign t_c2r_d  = rise2 ? cnt_q : t_c2r_q;
    assign t_c2f_d  = fall2 ? cnt_q : t_c2f_q;
    assign dup_now  = dup_q | (seen_c1f_q & fall1) | (seen_c2r_q & rise2) |
                      (seen_c2f_q & fall2);
    assign all_seen = (seen_c1f_q | fall1) & (seen_c2r_q | rise2) & (seen_c2f_q | fall2);
    assign ordered  = (t_c1f_d <= t_c2r_d) && (t_c2r_d <= t_c2f_d);
    assign st_now   = st_period_q | both;
    assign seq_ok   = all_seen & ~dup_now & ordered & ~st_now;

    assign ovf_hit    = (state_q == StMeasure) & ~rise1 & (cnt_q == CntNearMax);
    assign new_period = rise1 | ovf_hit | (state_q == StWaitEdge);

    always_comb begin
        state_d      = state_q;
        cnt_d        = rise1 ? CntOne : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne);
        seen_c1f_d   = seen_c1f_q | fall1;
        seen_c2r_d   = seen_c2r_q | rise2;
        seen_c2f_d   = seen_c2f_q | fall2;
        dup_d        = dup_now;
        st_period_d  = st_now;
        shoot_d      = shoot_q | both;
        period_d     = period_q;
        duty_d       = duty_q;
        dt1_d        = dt1_q;
        dt2_d        = dt2_q;
        meas_valid_d = 1'b0;
        seq_error_d  = 1'b0;
        overflow_d   = 1'b0;

        if (rise1) begin
            if (state_q == StMeasure) begin
                if (seq_ok) begin
                    period_d     = cnt_q;
                    duty_d       = t_c1f_d;
                    dt2_d        = t_c2r_d - t_c1f_d;
                    dt1_d        = cnt_q - t_c2f_d;
                    meas_valid_d = 1'b1;
                end else begin
                    seq_error_d = 1'b1;
                end
            end
            state_d = StMeasure;
        end else if (ovf_hit) begin
            overflow_d = 1'b1;
            state_d    = StWaitEdge;
        end

        if (new_period) begin
            seen_c1f_d  = 1'b0;
            seen_c2r_d  = 1'b0;
            seen_c2f_d  = 1'b0;
            dup_d       = 1'b0;
            st_period_d = rise1 & both;
        end
    end

    always_ff @(posedge hf_clock) begin
        if (reset) begin
            c1_sync_q    <= '0;
            c2_sync_q    <= '0;
            s1_prev_q    <= 1'b0;
            s2_prev_q    <= 1'b0;
            state_q      <= StWaitEdge;
            cnt_q        <= '0;
            t_c1f_q      <= '0;
            t_c2r_q      <= '0;
            t_c2f_q      <= '0;
            seen_c1f_q   <= 1'b0;
            seen_c2r_q   <= 1'b0;
            seen_c2f_q   <= 1'b0;
            dup_q        <= 1'b0;
            st_period_q  <= 1'b0;
            shoot_q      <= 1'b0;
            period_q     <= '0;
            duty_q       <= '0;
            dt1_q        <= '0;
            dt2_q        <= '0;
            meas_valid_q <= 1'b0;
            seq_error_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            c1_sync_q    <= {c1_sync_q[SYNC_STAGES-2:0], gate.c1};
            c2_sync_q    <= {c2_sync_q[SYNC_STAGES-2:0], gate.c2};
            s1_prev_q    <= s1;
            s2_prev_q    <= s2;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            t_c1f_q      <= t_c1f_d;
            t_c2r_q      <= t_c2r_d;
            t_c2f_q      <= t_c2f_d;
            seen_c1f_q   <= seen_c1f_d;
            seen_c2r_q   <= seen_c2r_d;
            seen_c2f_q   <= seen_c2f_d;
            dup_q        <= dup_d;
            st_period_q  <= st_period_d;
            shoot_q      <= shoot_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            dt1_q        <= dt1_d;
            dt2_q        <= dt2_d;
            meas_valid_q <= meas_valid_d;
            seq_error_q  <= seq_error_d;
            overflow_q   <= overflow_d;
        end
    end

    assign gate.period        = period_q;
    assign gate.duty_cycle    = duty_q;
    assign gate.deadtime1     = dt1_q;
    assign gate.deadtime2     = dt2_q;
    assign gate.meas_valid    = meas_valid_q;
    assign gate.seq_error     = seq_error_q;
    assign gate.overflow      = overflow_q;
    assign gate.shoot_through = shoot_q;
endmodule

// File: tb/tb_dpwm_capture.sv
// Scoreboard bench: per-cycle gate waveforms are analysed period by period to predict
// each result pulse; a monitor pops and compares whenever the DUT pulses.
module tb_dpwm_capture;
    localparam int unsigned RES  = 8;
    localparam int unsigned SYNC = 2;
    localparam int          MAXC = (1 << RES) - 1;

    typedef struct {
        int kind;  // 0 meas_valid, 1 seq_error, 2 overflow
        int per;
        int duty;
        int dt1;
        int dt2;
        bit st;
    } exp_t;

    logic hf_clock = 1'b0;
    logic reset    = 1'b1;
    exp_t exp_q[$];
    bit   lv1[$];
    bit   lv2[$];
    int   total = 0;
    int   bad   = 0;

    dpwm_capture_if #(.RESOLUTION(RES)) gate ();

    dpwm_capture #(
        .RESOLUTION (RES),
        .SYNC_STAGES(SYNC)
    ) dut (
        .hf_clock(hf_clock),
        .reset   (reset),
        .gate    (gate)
    );

    always #5 hf_clock = ~hf_clock;

    // c1 high on [0,a), c2 high on [b,e) and optionally [b2,e2), period p cycles.
    task automatic add_period(input int p, input int a, input int b, input int e,
                              input int b2 = 0, input int e2 = 0);
        for (int t = 0; t < p; t++) begin
            lv1.push_back(t < a);
            lv2.push_back((t >= b && t < e) || (t >= b2 && t < e2));
        end
    endtask

    function automatic bit both_any(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) if (lv1[j] && lv2[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_exp(input int kind, input int per, input int duty, input int dt1,
                            input int dt2, input bit st);
        exp_t x;
        x.kind = kind; x.per = per; x.duty = duty; x.dt1 = dt1; x.dt2 = dt2; x.st = st;
        exp_q.push_back(x);
    endtask

    // Samples closer than SYNC to the reset edge never reach the output.
    task automatic run_model();
        int last;
        int rises[$];
        bit meas;
        int r, hp, hd, h1, h2;
        last = lv1.size() - 1 - SYNC;
        meas = 0; r = 0; hp = 0; hd = 0; h1 = 0; h2 = 0;
        for (int i = 0; i <= last; i++)
            if (lv1[i] && (i == 0 || !lv1[i-1])) rises.push_back(i);
        foreach (rises[k]) begin
            int rr, n1f, n2r, n2f, t1f, t2r, t2f;
            rr = rises[k];
            if (meas && rr - r >= MAXC) begin
                push_exp(2, hp, hd, h1, h2, both_any(0, r + MAXC - 1));
                meas = 0;
            end
            if (meas) begin
                n1f = 0; n2r = 0; n2f = 0; t1f = 0; t2r = 0; t2f = 0;
                for (int j = r + 1; j <= rr; j++) begin
                    if (!lv1[j] && lv1[j-1]) begin n1f++; t1f = j - r; end
                    if (lv2[j] && !lv2[j-1]) begin n2r++; t2r = j - r; end
                    if (!lv2[j] && lv2[j-1]) begin n2f++; t2f = j - r; end
                end
                if (n1f == 1 && n2r == 1 && n2f == 1 && t1f <= t2r && t2r <= t2f &&
                    !both_any(r, rr)) begin
                    hp = rr - r; hd = t1f; h2 = t2r - t1f; h1 = (rr - r) - t2f;
                    push_exp(0, hp, hd, h1, h2, both_any(0, rr));
                end else begin
                    push_exp(1, hp, hd, h1, h2, both_any(0, rr));
                end
            end
            meas = 1; r = rr;
        end
        if (meas && r + MAXC - 1 <= last)
            push_exp(2, hp, hd, h1, h2, both_any(0, r + MAXC - 1));
    endtask

    task automatic check_reset_state(input string tag);
        logic [4*RES+3:0] got;
        got = {gate.period, gate.duty_cycle, gate.deadtime1, gate.deadtime2,
               gate.meas_valid, gate.seq_error, gate.overflow, gate.shoot_through};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_state(%s): got %h want 0", tag, got);
        end
    endtask

    task automatic run_segment(input string tag);
        int n;
        bit st_exp;
        n = lv1.size();
        run_model();
        st_exp = both_any(0, n - 1 - SYNC);
        @(negedge hf_clock);
        reset = 1'b0; gate.c1 = lv1[0]; gate.c2 = lv2[0];
        for (int k = 1; k < n; k++) begin
            @(negedge hf_clock);
            gate.c1 = lv1[k]; gate.c2 = lv2[k];
        end
        @(negedge hf_clock);
        total++;
        if (gate.shoot_through !== st_exp) begin
            bad++;
            $display("FAIL shoot_sticky(%s): got %b want %b", tag, gate.shoot_through, st_exp);
        end
        reset = 1'b1; gate.c1 = 1'b0; gate.c2 = 1'b0;
        @(negedge hf_clock);
        check_reset_state(tag);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses(%s): got %0d left want 0", tag, exp_q.size());
        end
        exp_q.delete();
        lv1.delete();
        lv2.delete();
    endtask

    always @(negedge hf_clock) begin
        exp_t e;
        int   kind;
        if (gate.meas_valid || gate.seq_error || gate.overflow) begin
            kind = gate.meas_valid ? 0 : (gate.seq_error ? 1 : 2);
            total++;
            if (int'(gate.meas_valid) + int'(gate.seq_error) + int'(gate.overflow) > 1) begin
                bad++;
                $display("FAIL pulse_exclusive: got mv=%b se=%b ov=%b want one",
                         gate.meas_valid, gate.seq_error, gate.overflow);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d want none at %0t", kind, $time);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind) begin
                    bad++;
                    $display("FAIL pulse_kind: got %0d want %0d at %0t", kind, e.kind, $time);
                end
                total++;
                if (int'(gate.period) != e.per || int'(gate.duty_cycle) != e.duty ||
                    int'(gate.deadtime1) != e.dt1 || int'(gate.deadtime2) != e.dt2) begin
                    bad++;
                    $display("FAIL results: got p=%0d d=%0d dt1=%0d dt2=%0d want p=%0d d=%0d dt1=%0d dt2=%0d",
                             gate.period, gate.duty_cycle, gate.deadtime1, gate.deadtime2,
                             e.per, e.duty, e.dt1, e.dt2);
                end
                total++;
                if (gate.shoot_through !== e.st) begin
                    bad++;
                    $display("FAIL shoot_at_pulse: got %b want %b", gate.shoot_through, e.st);
                end
            end
        end
    end

    initial begin
        int p, a, b, e, b2, e2, f;
        gate.c1 = 1'b0;
        gate.c2 = 1'b0;
        repeat (3) @(negedge hf_clock);
        check_reset_state("power_on");

        add_period(3, 0, 0, 0);
        repeat (5) add_period(100, 40, 45, 95);
        add_period(9, 1, 0, 0);
        run_segment("steady");

        add_period(3, 0, 0, 0);
        repeat (3) add_period(50, 30, 30, 50);
        add_period(9, 1, 0, 0);
        run_segment("zero_deadtime");

        add_period(3, 0, 0, 0);
        add_period(100, 40, 45, 95);
        add_period(100, 40, 38, 95);
        repeat (2) add_period(100, 40, 45, 95);
        add_period(9, 1, 0, 0);
        run_segment("shoot_through");

        add_period(3, 0, 0, 0);
        add_period(100, 40, 45, 95);
        add_period(310, 10, 20, 30);
        repeat (2) add_period(50, 20, 25, 45);
        add_period(9, 1, 0, 0);
        run_segment("overflow");

        add_period(3, 0, 0, 0);
        repeat (2) add_period(100, 40, 45, 95);
        add_period(100, 40, 0, 0);
        repeat (2) add_period(100, 40, 45, 95);
        add_period(9, 1, 0, 0);
        run_segment("missing_c2");

        add_period(3, 0, 0, 0);
        add_period(100, 40, 45, 95);
        add_period(100, 40, 45, 60, 70, 90);
        add_period(100, 40, 45, 95);
        add_period(9, 1, 0, 0);
        run_segment("duplicate_c2");

        add_period(3, 0, 0, 0);
        repeat (3) add_period(100, 40, 45, 95);
        add_period(20, 40, 45, 95);
        run_segment("reset_mid_period");

        add_period(3, 0, 0, 0);
        repeat (6) add_period(2, 1, 1, 2);
        add_period(9, 1, 0, 0);
        run_segment("min_period");

        for (int s = 0; s < 6; s++) begin
            add_period(3, 0, 0, 0);
            for (int k = 0; k < 8; k++) begin
                p = $urandom_range(120, 4);
                a = $urandom_range(p - 3, 1);
                b = $urandom_range(p - 2, a);
                e = $urandom_range(p, b + 1);
                b2 = 0; e2 = 0;
                f = $urandom_range(11, 0);
                if (f == 7) begin
                    b = 0; e = 0;
                end else if (f == 8 && a >= 2) begin
                    b = a - 1;
                end else if (f == 9 && e - b >= 3) begin
                    b2 = b + 2; e2 = e; e = b + 1;
                end else if (f == 10) begin
                    p = $urandom_range(300, 256);
                end
                add_period(p, a, b, e, b2, e2);
            end
            add_period(9, 1, 0, 0);
            run_segment("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
